// File: rtl/uart_tx_param.sv
// rtl/uart_tx_param.sv - parametrised UART transmitter (start, 5..9 data bits, optional parity, stop).
module uart_tx_param #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int SB_TICKS   = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] dato_in,
    output logic                 dato_out,
    output logic                 tx_done_tick,
    output logic                 busy
);

    localparam int S_MAX = (OVERSAMPLE > SB_TICKS) ? OVERSAMPLE : SB_TICKS;
    localparam int S_W   = $clog2(S_MAX);
    localparam int N_W   = $clog2(DATA_BITS);

    localparam logic [S_W-1:0] S_OV_LAST = S_W'(OVERSAMPLE - 1);
    localparam logic [S_W-1:0] S_SB_LAST = S_W'(SB_TICKS - 1);
    localparam logic [N_W-1:0] N_LAST    = N_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               r_state;
    logic [S_W-1:0]       r_s;
    logic [N_W-1:0]       r_n;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_parity;
    logic                 r_tx;
    logic                 r_done;
    logic                 r_busy;

    state_t               w_state;
    logic [S_W-1:0]       w_s;
    logic [N_W-1:0]       w_n;
    logic [DATA_BITS-1:0] w_shift;
    logic                 w_parity;
    logic                 w_tx;
    logic                 w_done;
    logic                 w_busy;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= IDLE;
            r_s      <= '0;
            r_n      <= '0;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_tx     <= 1'b1;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_s      <= w_s;
            r_n      <= w_n;
            r_shift  <= w_shift;
            r_parity <= w_parity;
            r_tx     <= w_tx;
            r_done   <= w_done;
            r_busy   <= w_busy;
        end
    end

    // A tick landing on the acceptance edge is not counted: IDLE never looks at tick.
    always_comb begin
        w_state  = r_state;
        w_s      = r_s;
        w_n      = r_n;
        w_shift  = r_shift;
        w_parity = r_parity;
        w_done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (tx_start) begin
                    w_state  = START;
                    w_s      = '0;
                    w_shift  = dato_in;
                    w_parity = (^dato_in) ^ 1'(PARITY_ODD);
                end
            end
            START: begin
                if (tick) begin
                    if (r_s == S_OV_LAST) begin
                        w_s     = '0;
                        w_n     = '0;
                        w_state = DATA;
                    end else begin
                        w_s = r_s + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (r_s == S_OV_LAST) begin
                        w_s     = '0;
                        w_shift = r_shift >> 1;
                        if (r_n == N_LAST) begin
                            w_state = (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            w_n = r_n + 1'b1;
                        end
                    end else begin
                        w_s = r_s + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    if (r_s == S_OV_LAST) begin
                        w_s     = '0;
                        w_state = STOP;
                    end else begin
                        w_s = r_s + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (r_s == S_SB_LAST) begin
                        w_s     = '0;
                        w_state = IDLE;
                        w_done  = 1'b1;
                    end else begin
                        w_s = r_s + 1'b1;
                    end
                end
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    // Line level is decoded from the next state so it is registered alongside it.
    always_comb begin
        w_tx = 1'b1;
        case (w_state)
            START:   w_tx = 1'b0;
            DATA:    w_tx = w_shift[0];
            PARITY:  w_tx = w_parity;
            default: w_tx = 1'b1;
        endcase
    end

    assign w_busy       = (w_state != IDLE);
    assign dato_out     = r_tx;
    assign tx_done_tick = r_done;
    assign busy         = r_busy;

endmodule

// File: tb/tb_uart_tx_param.sv
// tb/tb_uart_tx_param.sv - scoreboard bench for uart_tx_param over four parameter sets.
module tb_uart_tx_param;

    typedef struct packed {
        logic [8:0] data;
        logic       par;
    } exp_t;

    logic       clock;
    logic [3:0] rst;
    logic [3:0] tx_start;
    logic [8:0] din [4];
    logic       tick_slow;
    logic [3:0] tick;
    logic [3:0] dout;
    logic [3:0] done;
    logic [3:0] busy;

    int checks;
    int errors;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    exp_t q3[$];

    assign tick = {tick_slow, 3'b111};

    uart_tx_param u_dut0 (
        .clock(clock), .reset(rst[0]), .tick(tick[0]), .tx_start(tx_start[0]),
        .dato_in(din[0][7:0]), .dato_out(dout[0]), .tx_done_tick(done[0]), .busy(busy[0])
    );

    uart_tx_param #(.PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (
        .clock(clock), .reset(rst[1]), .tick(tick[1]), .tx_start(tx_start[1]),
        .dato_in(din[1][7:0]), .dato_out(dout[1]), .tx_done_tick(done[1]), .busy(busy[1])
    );

    uart_tx_param #(.PARITY_EN(1), .PARITY_ODD(1)) u_dut2 (
        .clock(clock), .reset(rst[2]), .tick(tick[2]), .tx_start(tx_start[2]),
        .dato_in(din[2][7:0]), .dato_out(dout[2]), .tx_done_tick(done[2]), .busy(busy[2])
    );

    uart_tx_param #(.DATA_BITS(7), .SB_TICKS(32)) u_dut3 (
        .clock(clock), .reset(rst[3]), .tick(tick[3]), .tx_start(tx_start[3]),
        .dato_in(din[3][6:0]), .dato_out(dout[3]), .tx_done_tick(done[3]), .busy(busy[3])
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        tick_slow = 1'b0;
        forever begin
            repeat (3) @(posedge clock);
            #1 tick_slow = 1'b1;
            @(posedge clock);
            #1 tick_slow = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic void push_exp(input int g, input exp_t e);
        case (g)
            0: q0.push_back(e);
            1: q1.push_back(e);
            2: q2.push_back(e);
            default: q3.push_back(e);
        endcase
    endfunction

    function automatic void pop_exp(input int g, output exp_t e, output bit ok);
        ok = 1'b0;
        e  = '0;
        case (g)
            0: if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
            2: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
            default: if (q3.size() > 0) begin e = q3.pop_front(); ok = 1'b1; end
        endcase
    endfunction

    // Monitors: record the line once per consumed tick while busy, compare on tx_done_tick.
    for (genvar g = 0; g < 4; g++) begin : g_mon
        localparam int P_DB = (g == 3) ? 7 : 8;
        localparam int P_OV = 16;
        localparam int P_SB = (g == 3) ? 32 : 16;
        localparam int P_PE = (g == 1 || g == 2) ? 1 : 0;

        initial begin
            logic [255:0] act;
            logic [255:0] ev;
            int           alen;
            int           el;
            logic         prev_done;
            exp_t         e;
            bit           ok;
            act       = '0;
            alen      = 0;
            prev_done = 1'b0;
            forever begin
                @(negedge clock);
                if (rst[g]) begin
                    act  = '0;
                    alen = 0;
                end else begin
                    if (done[g] === 1'b1) begin
                        chk($sformatf("g%0d_done_single", g), prev_done, 0);
                        pop_exp(g, e, ok);
                        chk($sformatf("g%0d_done_expected", g), ok, 1);
                        if (ok) begin
                            ev = '0;
                            el = 0;
                            for (int k = 0; k < P_OV; k++) begin ev[el] = 1'b0; el++; end
                            for (int i = 0; i < P_DB; i++)
                                for (int k = 0; k < P_OV; k++) begin ev[el] = e.data[i]; el++; end
                            if (P_PE != 0)
                                for (int k = 0; k < P_OV; k++) begin ev[el] = e.par; el++; end
                            for (int k = 0; k < P_SB; k++) begin ev[el] = 1'b1; el++; end
                            chk($sformatf("g%0d_frame_len", g), alen, el);
                            chk($sformatf("g%0d_frame_bits", g), act, ev);
                        end
                        act  = '0;
                        alen = 0;
                    end
                    if (busy[g] === 1'b1 && tick[g]) begin
                        if (alen < 256) act[alen] = dout[g];
                        alen++;
                    end
                end
                prev_done = done[g];
            end
        end
    end

    task automatic start_pulse(input int g, input logic [8:0] d);
        din[g]      = d;
        tx_start[g] = 1'b1;
        @(posedge clock);
        #1 tx_start[g] = 1'b0;
    endtask

    task automatic wait_done(input int g, input int maxc);
        int c;
        c = 0;
        while (done[g] !== 1'b1 && c < maxc) begin
            @(negedge clock);
            c++;
        end
        chk($sformatf("g%0d_done_seen", g), done[g], 1);
    endtask

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 4'hF;
        tx_start = 4'h0;
        for (int i = 0; i < 4; i++) din[i] = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("g%0d_reset_line", g), dout[g], 1);
            chk($sformatf("g%0d_reset_busy", g), busy[g], 0);
            chk($sformatf("g%0d_reset_done", g), done[g], 0);
        end
        @(posedge clock);
        #1 rst = 4'h0;

        // Parity and 7E-less/2-stop variants run in the background.
        push_exp(1, '{data: 9'h025, par: 1'b1});
        push_exp(2, '{data: 9'h025, par: 1'b0});
        push_exp(3, '{data: 9'h05A, par: 1'b0});
        din[1] = 9'h025;
        din[2] = 9'h025;
        din[3] = 9'h05A;
        tx_start[3:1] = 3'b111;
        @(posedge clock);
        #1 tx_start[3:1] = 3'b000;

        push_exp(0, '{data: 9'h025, par: 1'b0});
        start_pulse(0, 9'h025);
        wait_done(0, 400);
        @(posedge clock);
        #1;

        // Start request and new data mid-DATA must not disturb the frame.
        push_exp(0, '{data: 9'h025, par: 1'b0});
        start_pulse(0, 9'h025);
        repeat (60) @(posedge clock);
        #1;
        start_pulse(0, 9'h0FF);
        wait_done(0, 400);
        repeat (40) @(posedge clock);
        #1;

        // Abort during data bit 3.
        start_pulse(0, 9'h025);
        repeat (70) @(posedge clock);
        #1 rst[0] = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("g0_abort_line", dout[0], 1);
        chk("g0_abort_busy", busy[0], 0);
        chk("g0_abort_done", done[0], 0);
        @(posedge clock);
        #1 rst[0] = 1'b0;
        repeat (250) @(posedge clock);
        #1;
        push_exp(0, '{data: 9'h0C3, par: 1'b0});
        start_pulse(0, 9'h0C3);
        wait_done(0, 400);
        @(posedge clock);
        #1;

        // Back-to-back with tx_start held high.
        push_exp(0, '{data: 9'h025, par: 1'b0});
        push_exp(0, '{data: 9'h0C3, par: 1'b0});
        din[0]      = 9'h025;
        tx_start[0] = 1'b1;
        @(posedge clock);
        #1 din[0] = 9'h0C3;
        wait_done(0, 400);
        @(negedge clock);
        chk("g0_b2b_busy", busy[0], 1);
        chk("g0_b2b_start_bit", dout[0], 0);
        tx_start[0] = 1'b0;
        wait_done(0, 400);

        repeat (300) @(posedge clock);
        #1;
        chk("g0_queue_empty", q0.size(), 0);
        chk("g1_queue_empty", q1.size(), 0);
        chk("g2_queue_empty", q2.size(), 0);
        chk("g3_queue_empty", q3.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART serial transmitter, successor to the fixed 8N1 transmitter. Serialises one parallel word per frame onto dato_out, LSB first. It is paced by the oversampling tick from the baud-rate generator, with configurable data width, oversampling ratio, stop length and parity. Sits between the host-side data source and the TX pin, beside the receiver.

Parameters:
DATA_BITS, 8, data bits per frame (5..9)
OVERSAMPLE, 16, ticks per start/data/parity bit (>=2)
SB_TICKS, 16, ticks in stop period (16=1, 24=1.5, 32=2 stop bits at OVERSAMPLE=16)
PARITY_EN, 0, 1 inserts parity bit after data
PARITY_ODD, 0, 0 even parity, 1 odd parity (only when PARITY_EN=1)

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
tick  input  1  one-clock enable pulse at OVERSAMPLE x baud rate
tx_start  input  1  request to send dato_in; level-sampled each clock
dato_in  input  DATA_BITS  word to transmit, captured on accepted start
dato_out  output  1  serial line, idle high
tx_done_tick  output  1  one-clock pulse, frame complete
busy  output  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset (synchronous): state=IDLE, dato_out=1, tx_done_tick=0, busy=0, tick counter s=0, bit counter n=0, shift register cleared. Reset mid-frame aborts the frame: line high at the next edge, no tx_done_tick.
- All outputs are registered; dato_out never glitches.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: dato_out=1. If tx_start=1 at an edge, latch dato_in into the shift register and compute the parity bit (XOR of data, XOR PARITY_ODD). Then state=START, s=0. A tick coinciding with acceptance is not counted.
- Later changes to dato_in do not affect the frame in progress.
- START: dato_out=0. On each tick: if s==OVERSAMPLE-1, set s=0, n=0, state=DATA; else s++.
- DATA: dato_out=shift[0]. On tick with s==OVERSAMPLE-1: s=0, shift right. If n==DATA_BITS-1, go to PARITY when PARITY_EN=1, otherwise STOP. Else n++.
- PARITY: dato_out=parity bit; after OVERSAMPLE ticks, state=STOP.
- STOP: dato_out=1. On tick with s==SB_TICKS-1: state=IDLE, tx_done_tick=1 for exactly the next clock cycle.
- Frame length in ticks = OVERSAMPLE*(1+DATA_BITS+PARITY_EN)+SB_TICKS.
- Clocks without tick leave s, n, state and dato_out unchanged.
- tx_start while busy=1 is ignored (not queued).
- Back-to-back frames: tx_start high in the cycle where tx_done_tick=1 (state already IDLE) is accepted. The next start bit begins with no idle gap beyond the stop period.
- s width = clog2(max(OVERSAMPLE,SB_TICKS)); n width = clog2(DATA_BITS). Neither counter wraps outside its terminal compares.

Test Plan:
- 8N1, tick every clock, dato_in=0x25, one-cycle tx_start → line 0 for 16 clocks, then bits 1,0,1,0,0,1,0,0 at 16 clocks each, then 1 for 16 clocks. tx_done_tick pulses once, 160 ticks after start; busy high throughout.
- PARITY_EN=1, PARITY_EN even, 0x25 (three ones) → parity bit 1 after bit 7. PARITY_ODD=1 → parity bit 0. Frame is 176 ticks.
- SB_TICKS=32, DATA_BITS=7, tick every 4 clocks, 0x5A → 7 data bits 0,1,0,1,1,0,1. Stop high for 32 ticks (128 clocks) before tx_done_tick.
- tx_start pulsed mid-DATA with a different dato_in → ignored. Current frame is bit-exact, and exactly one tx_done_tick.
- reset asserted during DATA bit 3 → next edge: dato_out=1, busy=0, no tx_done_tick. A new tx_start afterwards produces a correct full frame.
- tx_start held high continuously with 0x25 then 0xC3 → second start bit begins the cycle after tx_done_tick. Two complete frames with correct data.
